// File: rtl/sum_requantizer.sv
// Requantizes a bit-grown signed sum back to ORI_WIDTH samples: shift by the
// growth, optional round-half-up, then saturate. Two-stage valid/ready pipeline.
module sum_requantizer #(
  parameter int NUM_INPUT = 8,
  parameter int ORI_WIDTH = 16,
  parameter int SUM_WIDTH = ORI_WIDTH + $clog2(NUM_INPUT),
  parameter int ROUND_EN  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [SUM_WIDTH-1:0] i_sum,
  input  logic        [7:0]           i_width,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [ORI_WIDTH-1:0] o_data,
  output logic                        o_sat,
  output logic        [15:0]          o_sat_count,
  input  logic                        i_clr_stats
);

  localparam int G_MAX = $clog2(NUM_INPUT);
  localparam int SW    = (G_MAX > 0) ? $clog2(G_MAX + 1) : 1;
  localparam int TW    = SUM_WIDTH + 1;

  localparam logic signed [TW-1:0] C_MAX = (TW'(1) << (ORI_WIDTH - 1)) - TW'(1);
  localparam logic signed [TW-1:0] C_MIN = -C_MAX - TW'(1);

  logic        [7:0]           w_diff;
  logic        [SW-1:0]        w_shift;
  logic        [TW-1:0]        w_bias;
  logic signed [TW-1:0]        w_t;
  logic signed [TW-1:0]        w_q;
  logic signed [ORI_WIDTH-1:0] w_qData;
  logic                        w_qSat;
  logic                        w_s1Rdy;
  logic                        w_s2Rdy;

  logic                        r_s1Valid;
  logic signed [TW-1:0]        r_t;
  logic        [SW-1:0]        r_s;
  logic                        r_s2Valid;
  logic signed [ORI_WIDTH-1:0] r_data;
  logic                        r_sat;
  logic        [15:0]          r_satCount;

  // Shift amount: growth above ORI_WIDTH, clamped to [0, G_MAX].
  always_comb begin
    w_diff = 8'd0;
    if (32'(i_width) > ORI_WIDTH) w_diff = i_width - 8'(ORI_WIDTH);
    if (32'(w_diff) > G_MAX) w_shift = SW'(G_MAX);
    else                     w_shift = w_diff[SW-1:0];
  end

  always_comb begin
    w_bias = '0;
    if (ROUND_EN != 0 && w_shift != '0) w_bias = TW'(1) << (w_shift - SW'(1));
  end

  assign w_t = $signed({i_sum[SUM_WIDTH-1], i_sum}) + $signed(w_bias);

  // Stage-2 arithmetic: shift the biased sum and clip to the output range.
  always_comb begin
    w_q     = r_t >>> r_s;
    w_qData = w_q[ORI_WIDTH-1:0];
    w_qSat  = 1'b0;
    if (w_q > C_MAX) begin
      w_qData = C_MAX[ORI_WIDTH-1:0];
      w_qSat  = 1'b1;
    end else if (w_q < C_MIN) begin
      w_qData = C_MIN[ORI_WIDTH-1:0];
      w_qSat  = 1'b1;
    end
  end

  assign w_s2Rdy = !r_s2Valid || i_ready;
  assign w_s1Rdy = !r_s1Valid || w_s2Rdy;
  assign o_ready = w_s1Rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Valid <= 1'b0;
      r_t       <= '0;
      r_s       <= '0;
    end else if (w_s1Rdy) begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_t <= w_t;
        r_s <= w_shift;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2Valid <= 1'b0;
      r_data    <= '0;
      r_sat     <= 1'b0;
    end else if (w_s2Rdy) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_data <= w_qData;
        r_sat  <= w_qSat;
      end
    end
  end

  // Clear wins over a same-cycle saturated transfer; the count sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_satCount <= 16'd0;
    end else if (i_clr_stats) begin
      r_satCount <= 16'd0;
    end else if (r_s2Valid && i_ready && r_sat && r_satCount != 16'hFFFF) begin
      r_satCount <= r_satCount + 16'd1;
    end
  end

  assign o_valid     = r_s2Valid;
  assign o_data      = r_data;
  assign o_sat       = r_sat;
  assign o_sat_count = r_satCount;

endmodule

// File: tb/tb_sum_requantizer.sv
// Bench for sum_requantizer: a rounding and a truncating instance share stimulus;
// expected {sat,data} pairs are queued on input transfer and compared on output transfer.
module tb_sum_requantizer;

  logic               clk;
  logic               rst_n;
  logic               i_valid;
  logic signed [18:0] i_sum;
  logic        [7:0]  i_width;
  logic               i_ready;
  logic               i_clr_stats;

  logic               o_ready,     o_ready_nr;
  logic               o_valid,     o_valid_nr;
  logic signed [15:0] o_data,      o_data_nr;
  logic               o_sat,       o_sat_nr;
  logic        [15:0] o_sat_count, o_sat_count_nr;

  logic [16:0] q1[$];
  logic [16:0] q2[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [16:0] SAT_HI = {1'b1, 16'h7FFF};
  localparam logic [16:0] SAT_LO = {1'b1, 16'h8000};

  sum_requantizer #(.NUM_INPUT(8), .ORI_WIDTH(16), .SUM_WIDTH(19), .ROUND_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sum(i_sum), .i_width(i_width), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_sat(o_sat), .o_sat_count(o_sat_count), .i_clr_stats(i_clr_stats)
  );

  sum_requantizer #(.NUM_INPUT(8), .ORI_WIDTH(16), .SUM_WIDTH(19), .ROUND_EN(0)) dut_nr (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready_nr),
    .i_sum(i_sum), .i_width(i_width), .o_valid(o_valid_nr), .i_ready(i_ready),
    .o_data(o_data_nr), .o_sat(o_sat_nr), .o_sat_count(o_sat_count_nr), .i_clr_stats(i_clr_stats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: outputs transfer at the next rising edge, so compare on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (o_valid_nr !== o_valid) begin
        failures++;
        $display("[TB] FAIL valid_match round=%0b trunc=%0b", o_valid, o_valid_nr);
      end
      if (o_valid && i_ready) begin
        checks++;
        if (q1.size() == 0 || q2.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_output data=%0d sat=%0b expected nothing", o_data, o_sat);
        end else begin
          logic [16:0] e1, e2;
          e1 = q1.pop_front();
          e2 = q2.pop_front();
          if ({o_sat, o_data} !== e1) begin
            failures++;
            $display("[TB] FAIL round_output got sat=%0b data=%0d expected sat=%0b data=%0d",
                     o_sat, o_data, e1[16], $signed(e1[15:0]));
          end
          checks++;
          if ({o_sat_nr, o_data_nr} !== e2) begin
            failures++;
            $display("[TB] FAIL trunc_output got sat=%0b data=%0d expected sat=%0b data=%0d",
                     o_sat_nr, o_data_nr, e2[16], $signed(e2[15:0]));
          end
        end
      end
    end
  end

  // Drive one sample from posedge+1 and hold it until accepted; queue its expectations.
  task automatic send(input logic signed [18:0] sum, input logic [7:0] width,
                      input logic [16:0] exp1, input logic [16:0] exp2);
    bit ok;
    ok = 1'b0;
    i_valid = 1'b1;
    i_sum   = sum;
    i_width = width;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      q1.push_back(exp1);
      q2.push_back(exp2);
    end else begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout o_ready=%0b expected 1", o_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain pending=%0d expected 0", name, q1.size());
    end
  endtask

  task automatic test_reset;
    checks += 4;
    if (o_valid !== 1'b0)         begin failures++; $display("[TB] FAIL reset_valid got %0b expected 0", o_valid); end
    if (o_data !== 16'sd0)        begin failures++; $display("[TB] FAIL reset_data got %0d expected 0", o_data); end
    if (o_sat !== 1'b0)           begin failures++; $display("[TB] FAIL reset_sat got %0b expected 0", o_sat); end
    if (o_sat_count !== 16'd0)    begin failures++; $display("[TB] FAIL reset_count got %0d expected 0", o_sat_count); end
  endtask

  task automatic test_basic;
    send(19'sd1000, 8'd18, {1'b0, 16'd250}, {1'b0, 16'd250});
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_early o_valid=%0b expected 0", o_valid); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL latency_two o_valid=%0b expected 1", o_valid); end
    @(posedge clk);
    #1;
    wait_drain("basic");
  endtask

  task automatic test_rounding;
    send(19'sd6,  8'd17, {1'b0, 16'd3},      {1'b0, 16'd3});
    send(-19'sd3, 8'd17, {1'b0, 16'hFFFF},   {1'b0, 16'hFFFE});
    send(19'sd7,  8'd17, {1'b0, 16'd4},      {1'b0, 16'd3});
    wait_drain("rounding");
  endtask

  task automatic test_saturation;
    send(19'sd40000,  8'd16, SAT_HI, SAT_HI);
    send(-19'sd40000, 8'd12, SAT_LO, SAT_LO);
    send(-19'sd40000, 8'd16, SAT_LO, SAT_LO);
    send(19'sd65535,  8'd17, SAT_HI, {1'b0, 16'h7FFF});
    send(19'sd80,     8'd30, {1'b0, 16'd10}, {1'b0, 16'd10});
    wait_drain("saturation");
    checks += 2;
    if (o_sat_count !== 16'd4)    begin failures++; $display("[TB] FAIL sat_count_round got %0d expected 4", o_sat_count); end
    if (o_sat_count_nr !== 16'd3) begin failures++; $display("[TB] FAIL sat_count_trunc got %0d expected 3", o_sat_count_nr); end
  endtask

  task automatic test_back_to_back_stall;
    int sums[5] = '{100, -200, 300, -400, 500};
    int sent, outstanding, k;
    bit holdValid, sawLow, expRdy;
    logic signed [15:0] held;
    sent = 0; outstanding = 0; k = 0; holdValid = 0; sawLow = 0; held = '0;
    while ((sent < 5 || outstanding > 0) && k < 60) begin
      i_ready = !(k >= 2 && k <= 6);
      i_valid = (sent < 5);
      if (sent < 5) begin
        i_sum   = 19'(sums[sent]);
        i_width = 8'd16;
      end
      @(negedge clk);
      expRdy = i_ready || (outstanding < 2);
      checks++;
      if (o_ready !== expRdy) begin
        failures++;
        $display("[TB] FAIL bp_ready cycle=%0d got %0b expected %0b", k, o_ready, expRdy);
      end
      if (!o_ready) sawLow = 1'b1;
      if (holdValid && o_valid) begin
        checks++;
        if (o_data !== held) begin
          failures++;
          $display("[TB] FAIL bp_stable cycle=%0d got %0d expected %0d", k, o_data, held);
        end
      end
      holdValid = o_valid && !i_ready;
      held = o_data;
      if (o_valid && i_ready) outstanding--;
      if (i_valid && o_ready) begin
        q1.push_back({1'b0, 16'(sums[sent])});
        q2.push_back({1'b0, 16'(sums[sent])});
        sent++;
        outstanding++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks += 2;
    if (!sawLow) begin failures++; $display("[TB] FAIL bp_ready_low got never-low expected low"); end
    if (sent != 5 || outstanding != 0) begin
      failures++;
      $display("[TB] FAIL bp_complete sent=%0d outstanding=%0d expected 5/0", sent, outstanding);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_counter_limits;
    bit seen;
    i_clr_stats = 1'b1;
    @(posedge clk);
    #1;
    i_clr_stats = 1'b0;
    checks++;
    if (o_sat_count !== 16'd0) begin failures++; $display("[TB] FAIL clr_idle got %0d expected 0", o_sat_count); end
    repeat (65537) send(19'sd40000, 8'd16, SAT_HI, SAT_HI);
    wait_drain("counter");
    checks += 2;
    if (o_sat_count !== 16'hFFFF)    begin failures++; $display("[TB] FAIL count_cap_round got %0h expected ffff", o_sat_count); end
    if (o_sat_count_nr !== 16'hFFFF) begin failures++; $display("[TB] FAIL count_cap_trunc got %0h expected ffff", o_sat_count_nr); end
    i_ready = 1'b0;
    send(19'sd40000, 8'd16, SAT_HI, SAT_HI);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = o_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL clr_setup o_valid=0 expected 1"); end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    i_clr_stats = 1'b1;
    @(posedge clk);
    #1;
    i_clr_stats = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o_sat_count !== 16'd0)    begin failures++; $display("[TB] FAIL clr_priority_round got %0d expected 0", o_sat_count); end
    if (o_sat_count_nr !== 16'd0) begin failures++; $display("[TB] FAIL clr_priority_trunc got %0d expected 0", o_sat_count_nr); end
    @(posedge clk);
    #1;
    wait_drain("clear");
  endtask

  task automatic test_reset_midop;
    bit seen;
    send(-19'sd40000, 8'd12, SAT_LO, SAT_LO);
    wait_drain("premid");
    checks++;
    if (o_sat_count !== 16'd1) begin failures++; $display("[TB] FAIL mid_precount got %0d expected 1", o_sat_count); end
    i_ready = 1'b0;
    send(19'sd1000, 8'd18, {1'b0, 16'd250}, {1'b0, 16'd250});
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = o_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("[TB] FAIL mid_setup o_valid=0 expected 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (o_valid !== 1'b0)      begin failures++; $display("[TB] FAIL mid_reset_valid got %0b expected 0", o_valid); end
    if (o_data !== 16'sd0)     begin failures++; $display("[TB] FAIL mid_reset_data got %0d expected 0", o_data); end
    if (o_sat_count !== 16'd0) begin failures++; $display("[TB] FAIL mid_reset_count got %0d expected 0", o_sat_count); end
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    send(19'sd1000, 8'd18, {1'b0, 16'd250}, {1'b0, 16'd250});
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_early o_valid=%0b expected 0", o_valid); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_latency o_valid=%0b expected 1", o_valid); end
    @(posedge clk);
    #1;
    wait_drain("postreset");
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_sum = '0;
    i_width = '0;
    i_ready = 1'b1;
    i_clr_stats = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back_stall();
    test_counter_limits();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
